rx_detection_sequencer: RTL and testbench
=========================================

# rx_detection_sequencer

Control block that sequences `rx_peak_identification` within the receive chain.
- Arms the peak search on host request and gates its enable.
- Consumes its trigger, value, sequence and timestamp, acknowledges it, and blanks detection for a hold-off period after each peak.
- Keeps the qualified result in a valid/ack holding register for the host (ARM) side, with timeout, overrun and detection-count status.

## Interface
Parameters:
- `HOLDOFF_SAMPLES`, 40800: new-sample strobes to stay blanked after a capture; 0 means leave hold-off on the next cycle.
- `TIMEOUT_SAMPLES`, 0: new-sample strobes allowed in ARMED before giving up; 0 disables the timeout.
- `MIN_PEAK`, 1000: signed minimum peak value for a capture to be reported.

Ports:
- `crx_clk`  in  1  clock; single clock domain.
- `rrx_rst`  in  1  reset, synchronous, active-high.
- `erx_en`  in  1  block enable; low behaves exactly as reset.
- `istart`  in  1  host arm request, level or pulse.
- `iabort`  in  1  host abort.
- `icontinuous`  in  1  1 = re-arm after hold-off, 0 = single shot.
- `inew_sample_trigger`  in  1  one-cycle strobe per ADC sample.
- `ipeak_trigger`  in  1  peak block final trigger.
- `ipeak_value`  in  41 signed  peak block peak value.
- `ipeak_seq`  in  4  peak block sequence index.
- `ipeak_time`  in  16  peak block timestamp.
- `iresult_ack`  in  1  host has read the result.
- `open_en`  out  1  enable to the peak block.
- `oacq_ack`  out  1  one-cycle pulse to the peak block's result-acquired input.
- `oresult_valid`  out  1  result register holds an unread result.
- `oresult_value`  out  41 signed  latched peak value.
- `oresult_seq`  out  4  latched sequence index.
- `oresult_time`  out  16  latched timestamp.
- `otimeout`  out  1  one-cycle pulse when the timeout expires.
- `ooverrun`  out  1  sticky flag: an unread result was overwritten.
- `obusy`  out  1  high when state is not IDLE.
- `odetect_count`  out  16  reported captures, saturating at 0xFFFF.

## Operation
FSM states are IDLE, ARMED and HOLDOFF. A 32-bit sample counter counts `inew_sample_trigger` strobes and is cleared on every state entry.

IDLE:
- `open_en` = 0.
- `istart` = 1 → ARMED.

ARMED:
- `open_en` = 1; the counter counts strobes. Priority is abort > peak > timeout.
- `iabort` → IDLE.
- `ipeak_trigger` → capture, then HOLDOFF.
- `TIMEOUT_SAMPLES` ≠ 0 and counter == `TIMEOUT_SAMPLES` → pulse `otimeout`, then IDLE.

Capture (on the ARMED→HOLDOFF edge):
- `oacq_ack` pulses for one cycle.
- If `ipeak_value` >= `MIN_PEAK` (signed compare):
  - latch value, seq and time;
  - set `oresult_valid`;
  - increment `odetect_count` (saturating);
  - if `oresult_valid` was already 1 and `iresult_ack` is 0 that cycle, set `ooverrun`.
- Otherwise the peak is discarded, and the result registers and flags are unchanged.

HOLDOFF:
- `open_en` = 0, which clears the peak block's internal state.
- Counter reaches `HOLDOFF_SAMPLES` → ARMED if `icontinuous`, else IDLE.
- `iabort` → IDLE.

Result register:
- `iresult_ack` clears `oresult_valid` and `ooverrun`.
- Ack and a qualifying capture in the same cycle: the capture wins, `oresult_valid` stays 1, and `ooverrun` is not set.
- Result registers change only on a qualifying capture or reset.

Ignored inputs:
- `istart` outside IDLE.
- `ipeak_trigger` outside ARMED.

## Timing
- Reset or `erx_en` = 0 (including mid-operation): next edge gives state IDLE and counter 0. All outputs go to 0: `open_en`, `oacq_ack`, `oresult_valid`, `oresult_value`, `oresult_seq`, `oresult_time`, `otimeout`, `ooverrun`, `obusy`, `odetect_count`.
- `istart` sampled high at edge N: state ARMED and `open_en` = 1 from N+1.
- `ipeak_trigger` sampled high at edge N in ARMED: from N+1:
  - `oacq_ack` = 1 for exactly that cycle;
  - `oresult_*` and `oresult_valid` updated;
  - `open_en` = 0;
  - state HOLDOFF.
- HOLDOFF exit one cycle after the edge where the counter equals `HOLDOFF_SAMPLES`. With `HOLDOFF_SAMPLES` = 0, HOLDOFF lasts exactly 1 cycle.
- `otimeout` is high for exactly one cycle, coincident with the IDLE entry.
- `obusy` is registered and follows the state with zero added latency.
- The counter increments only on strobe cycles. Compares use the registered count, so the exit happens on the cycle after the threshold strobe.

## Test plan
1. Reset, `istart` pulse, `ipeak_trigger` with value 5000, seq 7, time 0x1234 → next cycle `oacq_ack` = 1, `oresult_valid` = 1 with 5000/7/0x1234, `open_en` = 0, `odetect_count` = 1. With `icontinuous` = 0 and `HOLDOFF_SAMPLES` = 4, after 4 strobes → IDLE, `obusy` = 0.
2. Peak value 999 with `MIN_PEAK` = 1000 → `oacq_ack` pulses, `oresult_valid` stays 0, `odetect_count` unchanged, HOLDOFF entered.
3. Continuous mode, two qualifying peaks with no ack between them → second result overwrites the first, `ooverrun` = 1, count = 2. Then `iresult_ack` → `oresult_valid` = 0 and `ooverrun` = 0.
4. `TIMEOUT_SAMPLES` = 10, no peak → after the 10th strobe, `otimeout` is a one-cycle pulse and state is IDLE. Repeat with `ipeak_trigger` on the same cycle as the timeout → capture wins, no `otimeout`.
5. `iabort` and `ipeak_trigger` in the same ARMED cycle → IDLE, no `oacq_ack`, no capture. Drop `erx_en` during HOLDOFF → all outputs 0 next cycle.
6. `iresult_ack` and a qualifying capture on the same cycle with valid already 1 → `oresult_valid` = 1 with new data, `ooverrun` = 0. Drive the count to 0xFFFF → it saturates.

Source files
------------

// File: rtl/rx_detection_sequencer.sv
// Sequencer for rx_peak_identification: arms the peak search, acknowledges and qualifies
// each peak, blanks detection for a hold-off window, and holds the result for the host.
module rx_detection_sequencer #(
    parameter int unsigned HOLDOFF_SAMPLES = 40800,
    parameter int unsigned TIMEOUT_SAMPLES = 0,
    parameter int          MIN_PEAK        = 1000,
    parameter logic [15:0] DETECT_MAX      = 16'hFFFF
) (
    input  logic               crx_clk,
    input  logic               rrx_rst,
    input  logic               erx_en,
    input  logic               istart,
    input  logic               iabort,
    input  logic               icontinuous,
    input  logic               inew_sample_trigger,
    input  logic               ipeak_trigger,
    input  logic signed [40:0] ipeak_value,
    input  logic        [3:0]  ipeak_seq,
    input  logic        [15:0] ipeak_time,
    input  logic               iresult_ack,
    output logic               open_en,
    output logic               oacq_ack,
    output logic               oresult_valid,
    output logic signed [40:0] oresult_value,
    output logic        [3:0]  oresult_seq,
    output logic        [15:0] oresult_time,
    output logic               otimeout,
    output logic               ooverrun,
    output logic               obusy,
    output logic        [15:0] odetect_count
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF} state_t;

    localparam logic signed [40:0] MinPeak = 41'(MIN_PEAK);
    localparam logic        [31:0] Holdoff = 32'(HOLDOFF_SAMPLES);
    localparam logic        [31:0] Timeout = 32'(TIMEOUT_SAMPLES);

    state_t             state_q;
    logic        [31:0] cnt_q;
    logic               open_en_q, acq_ack_q, valid_q, timeout_q, overrun_q, busy_q;
    logic signed [40:0] value_q;
    logic        [3:0]  seq_q;
    logic        [15:0] time_q, count_q;
    logic               qualify_d;
    logic        [15:0] count_d;

    always_comb begin
        qualify_d = (ipeak_value >= MinPeak);
        count_d   = (count_q != DETECT_MAX) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge crx_clk) begin
        if (rrx_rst || !erx_en) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            open_en_q <= 1'b0;
            acq_ack_q <= 1'b0;
            valid_q   <= 1'b0;
            value_q   <= '0;
            seq_q     <= '0;
            time_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            acq_ack_q <= 1'b0;
            timeout_q <= 1'b0;
            if (inew_sample_trigger) cnt_q <= cnt_q + 32'd1;
            if (iresult_ack) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (istart) begin
                        state_q   <= S_ARMED;
                        cnt_q     <= '0;
                        open_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (iabort) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        open_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (ipeak_trigger) begin
                        state_q   <= S_HOLDOFF;
                        cnt_q     <= '0;
                        open_en_q <= 1'b0;
                        acq_ack_q <= 1'b1;
                        // A qualifying capture overrides a same-cycle ack.
                        if (qualify_d) begin
                            value_q <= ipeak_value;
                            seq_q   <= ipeak_seq;
                            time_q  <= ipeak_time;
                            valid_q <= 1'b1;
                            count_q <= count_d;
                            if (valid_q && !iresult_ack) overrun_q <= 1'b1;
                        end
                    end else if (Timeout != 32'd0 && cnt_q == Timeout) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        open_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (iabort || (cnt_q == Holdoff && !icontinuous)) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        open_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (cnt_q == Holdoff) begin
                        state_q   <= S_ARMED;
                        cnt_q     <= '0;
                        open_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    open_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign open_en       = open_en_q;
    assign oacq_ack      = acq_ack_q;
    assign oresult_valid = valid_q;
    assign oresult_value = value_q;
    assign oresult_seq   = seq_q;
    assign oresult_time  = time_q;
    assign otimeout      = timeout_q;
    assign ooverrun      = overrun_q;
    assign obusy         = busy_q;
    assign odetect_count = count_q;

endmodule

// File: tb/tb_rx_detection_sequencer.sv
// Directed bench for rx_detection_sequencer: per-cycle vector table plus hand sequences
// for timeout, abort, enable drop, ack/capture collision and count saturation.
module tb_rx_detection_sequencer;

    logic               crx_clk = 1'b0;
    logic               rrx_rst, erx_en, istart, iabort, icontinuous;
    logic               inew_sample_trigger, ipeak_trigger, iresult_ack;
    logic signed [40:0] ipeak_value;
    logic        [3:0]  ipeak_seq;
    logic        [15:0] ipeak_time;

    logic               open_en, oacq_ack, oresult_valid, otimeout, ooverrun, obusy;
    logic signed [40:0] oresult_value;
    logic        [3:0]  oresult_seq;
    logic        [15:0] oresult_time, odetect_count;

    logic               s_open_en, s_acq_ack, s_valid, s_timeout, s_overrun, s_busy;
    logic signed [40:0] s_value;
    logic        [3:0]  s_seq;
    logic        [15:0] s_time, s_count;

    int checks = 0;
    int errors = 0;

    always #5 crx_clk = ~crx_clk;

    rx_detection_sequencer #(
        .HOLDOFF_SAMPLES(4), .TIMEOUT_SAMPLES(10), .MIN_PEAK(1000)
    ) dut (
        .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en), .istart(istart),
        .iabort(iabort), .icontinuous(icontinuous), .inew_sample_trigger(inew_sample_trigger),
        .ipeak_trigger(ipeak_trigger), .ipeak_value(ipeak_value), .ipeak_seq(ipeak_seq),
        .ipeak_time(ipeak_time), .iresult_ack(iresult_ack), .open_en(open_en),
        .oacq_ack(oacq_ack), .oresult_valid(oresult_valid), .oresult_value(oresult_value),
        .oresult_seq(oresult_seq), .oresult_time(oresult_time), .otimeout(otimeout),
        .ooverrun(ooverrun), .obusy(obusy), .odetect_count(odetect_count)
    );

    rx_detection_sequencer #(
        .HOLDOFF_SAMPLES(0), .TIMEOUT_SAMPLES(0), .MIN_PEAK(1000), .DETECT_MAX(16'd3)
    ) dut_sat (
        .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en), .istart(istart),
        .iabort(iabort), .icontinuous(icontinuous), .inew_sample_trigger(inew_sample_trigger),
        .ipeak_trigger(ipeak_trigger), .ipeak_value(ipeak_value), .ipeak_seq(ipeak_seq),
        .ipeak_time(ipeak_time), .iresult_ack(iresult_ack), .open_en(s_open_en),
        .oacq_ack(s_acq_ack), .oresult_valid(s_valid), .oresult_value(s_value),
        .oresult_seq(s_seq), .oresult_time(s_time), .otimeout(s_timeout),
        .ooverrun(s_overrun), .obusy(s_busy), .odetect_count(s_count)
    );

    typedef struct {
        logic [5:0]         in;     // {start, abort, continuous, strobe, peak, ack}
        logic signed [40:0] pv;
        logic [3:0]         ps;
        logic [15:0]        pt;
        logic [4:0]         ex;     // {open_en, acq_ack, valid, overrun, busy}
        logic signed [40:0] ev;
        logic [3:0]         es;
        logic [15:0]        et;
        logic [15:0]        ec;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic [5:0] in, logic signed [40:0] pv, logic [3:0] ps,
                                logic [15:0] pt, logic [4:0] ex, logic signed [40:0] ev,
                                logic [3:0] es, logic [15:0] et, logic [15:0] ec);
        vec_t v;
        v.in = in; v.pv = pv; v.ps = ps; v.pt = pt;
        v.ex = ex; v.ev = ev; v.es = es; v.et = et; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge crx_clk);
        #1;
    endtask

    task automatic idle_in();
        istart = 0; iabort = 0; inew_sample_trigger = 0; ipeak_trigger = 0;
        iresult_ack = 0; ipeak_value = '0; ipeak_seq = '0; ipeak_time = '0;
    endtask

    task automatic peak(input logic signed [40:0] v, input logic [3:0] s, input logic [15:0] t);
        ipeak_trigger = 1; ipeak_value = v; ipeak_seq = s; ipeak_time = t;
    endtask

    initial begin
        // single shot capture, then four strobes of hold-off
        vecs[0]  = mk(6'b100000, 0,    0, 16'h0000, 5'b10001, 0,    0, 16'h0000, 0);
        vecs[1]  = mk(6'b000010, 5000, 7, 16'h1234, 5'b01101, 5000, 7, 16'h1234, 1);
        vecs[2]  = mk(6'b000100, 0,    0, 16'h0000, 5'b00101, 5000, 7, 16'h1234, 1);
        vecs[3]  = mk(6'b000100, 0,    0, 16'h0000, 5'b00101, 5000, 7, 16'h1234, 1);
        vecs[4]  = mk(6'b000100, 0,    0, 16'h0000, 5'b00101, 5000, 7, 16'h1234, 1);
        vecs[5]  = mk(6'b000100, 0,    0, 16'h0000, 5'b00101, 5000, 7, 16'h1234, 1);
        vecs[6]  = mk(6'b000000, 0,    0, 16'h0000, 5'b00100, 5000, 7, 16'h1234, 1);
        // ack, then a sub-threshold peak and abort out of hold-off
        vecs[7]  = mk(6'b000001, 0,    0, 16'h0000, 5'b00000, 5000, 7, 16'h1234, 1);
        vecs[8]  = mk(6'b100000, 0,    0, 16'h0000, 5'b10001, 5000, 7, 16'h1234, 1);
        vecs[9]  = mk(6'b000010, 999,  3, 16'h0BAD, 5'b01001, 5000, 7, 16'h1234, 1);
        vecs[10] = mk(6'b010000, 0,    0, 16'h0000, 5'b00000, 5000, 7, 16'h1234, 1);
        // continuous mode: two captures without ack give overrun
        vecs[11] = mk(6'b101000, 0,    0, 16'h0000, 5'b10001, 5000, 7, 16'h1234, 1);
        vecs[12] = mk(6'b001010, 2000, 1, 16'h0001, 5'b01101, 2000, 1, 16'h0001, 2);
        vecs[13] = mk(6'b001100, 0,    0, 16'h0000, 5'b00101, 2000, 1, 16'h0001, 2);
        vecs[14] = mk(6'b001100, 0,    0, 16'h0000, 5'b00101, 2000, 1, 16'h0001, 2);
        vecs[15] = mk(6'b001100, 0,    0, 16'h0000, 5'b00101, 2000, 1, 16'h0001, 2);
        vecs[16] = mk(6'b001100, 0,    0, 16'h0000, 5'b00101, 2000, 1, 16'h0001, 2);
        vecs[17] = mk(6'b001000, 0,    0, 16'h0000, 5'b10101, 2000, 1, 16'h0001, 2);
        vecs[18] = mk(6'b001010, 3000, 2, 16'h0002, 5'b01111, 3000, 2, 16'h0002, 3);
        vecs[19] = mk(6'b001001, 0,    0, 16'h0000, 5'b00001, 3000, 2, 16'h0002, 3);
        vecs[20] = mk(6'b010000, 0,    0, 16'h0000, 5'b00000, 3000, 2, 16'h0002, 3);
        // negative peak must fail the signed threshold
        vecs[21] = mk(6'b100000, 0,    0, 16'h0000, 5'b10001, 3000, 2, 16'h0002, 3);
        vecs[22] = mk(6'b000010, -5000, 9, 16'hFFFF, 5'b01001, 3000, 2, 16'h0002, 3);
        vecs[23] = mk(6'b010000, 0,    0, 16'h0000, 5'b00000, 3000, 2, 16'h0002, 3);

        rrx_rst = 1; erx_en = 1; icontinuous = 0;
        idle_in();
        tick(); tick();
        chk("rst open_en", 64'(open_en), 0);
        chk("rst valid", 64'(oresult_valid), 0);
        chk("rst busy", 64'(obusy), 0);
        chk("rst count", 64'(odetect_count), 0);
        chk("rst value", 64'(oresult_value), 0);
        rrx_rst = 0;

        for (int i = 0; i < 24; i++) begin
            idle_in();
            {istart, iabort, icontinuous, inew_sample_trigger, ipeak_trigger, iresult_ack} = vecs[i].in;
            ipeak_value = vecs[i].pv; ipeak_seq = vecs[i].ps; ipeak_time = vecs[i].pt;
            tick();
            chk($sformatf("v%0d open_en", i), 64'(open_en), 64'(vecs[i].ex[4]));
            chk($sformatf("v%0d acq_ack", i), 64'(oacq_ack), 64'(vecs[i].ex[3]));
            chk($sformatf("v%0d valid", i), 64'(oresult_valid), 64'(vecs[i].ex[2]));
            chk($sformatf("v%0d overrun", i), 64'(ooverrun), 64'(vecs[i].ex[1]));
            chk($sformatf("v%0d busy", i), 64'(obusy), 64'(vecs[i].ex[0]));
            chk($sformatf("v%0d value", i), 64'(oresult_value), 64'(vecs[i].ev));
            chk($sformatf("v%0d seq", i), 64'(oresult_seq), 64'(vecs[i].es));
            chk($sformatf("v%0d time", i), 64'(oresult_time), 64'(vecs[i].et));
            chk($sformatf("v%0d count", i), 64'(odetect_count), 64'(vecs[i].ec));
            chk($sformatf("v%0d timeout", i), 64'(otimeout), 0);
        end
        icontinuous = 0;

        // timeout after the tenth strobe
        idle_in(); istart = 1; tick();
        idle_in(); inew_sample_trigger = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("to pre busy", 64'(obusy), 1);
        chk("to pre pulse", 64'(otimeout), 0);
        idle_in(); tick();
        chk("to pulse", 64'(otimeout), 1);
        chk("to busy", 64'(obusy), 0);
        chk("to open_en", 64'(open_en), 0);
        tick();
        chk("to pulse width", 64'(otimeout), 0);

        // peak on the timeout cycle wins
        istart = 1; tick();
        idle_in(); inew_sample_trigger = 1;
        for (int i = 0; i < 10; i++) tick();
        idle_in(); peak(1500, 4, 16'h0044); tick();
        chk("tp acq", 64'(oacq_ack), 1);
        chk("tp timeout", 64'(otimeout), 0);
        chk("tp busy", 64'(obusy), 1);
        chk("tp value", 64'(oresult_value), 1500);
        chk("tp count", 64'(odetect_count), 4);
        idle_in(); iabort = 1; tick();
        chk("tp abort busy", 64'(obusy), 0);

        // abort beats a same-cycle peak
        idle_in(); istart = 1; tick();
        idle_in(); iabort = 1; peak(4000, 8, 16'h0088); tick();
        chk("ap busy", 64'(obusy), 0);
        chk("ap acq", 64'(oacq_ack), 0);
        chk("ap value", 64'(oresult_value), 1500);
        chk("ap count", 64'(odetect_count), 4);

        // enable drop during hold-off clears everything
        idle_in(); istart = 1; tick();
        idle_in(); peak(4242, 1, 16'h4242); tick();
        chk("en pre overrun", 64'(ooverrun), 1);
        chk("en pre count", 64'(odetect_count), 5);
        idle_in(); erx_en = 0; tick();
        chk("en open_en", 64'(open_en), 0);
        chk("en acq", 64'(oacq_ack), 0);
        chk("en valid", 64'(oresult_valid), 0);
        chk("en value", 64'(oresult_value), 0);
        chk("en seq", 64'(oresult_seq), 0);
        chk("en time", 64'(oresult_time), 0);
        chk("en timeout", 64'(otimeout), 0);
        chk("en overrun", 64'(ooverrun), 0);
        chk("en busy", 64'(obusy), 0);
        chk("en count", 64'(odetect_count), 0);
        erx_en = 1;

        // ack coincident with a qualifying capture
        istart = 1; tick();
        idle_in(); peak(1111, 5, 16'h0555); tick();
        chk("ac first valid", 64'(oresult_valid), 1);
        idle_in(); iabort = 1; tick();
        idle_in(); istart = 1; tick();
        idle_in(); peak(2222, 6, 16'h0666); iresult_ack = 1; tick();
        chk("ac valid", 64'(oresult_valid), 1);
        chk("ac value", 64'(oresult_value), 2222);
        chk("ac seq", 64'(oresult_seq), 6);
        chk("ac time", 64'(oresult_time), 16'h0666);
        chk("ac overrun", 64'(ooverrun), 0);
        chk("ac count", 64'(odetect_count), 2);
        idle_in(); iabort = 1; tick();

        // detection count saturation (instance saturating at 3)
        idle_in(); rrx_rst = 1; tick();
        rrx_rst = 0; istart = 1; icontinuous = 1; tick();
        idle_in(); peak(5000, 1, 16'h0001);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) chk("sat first", 64'(s_count), 1);
        end
        chk("sat count", 64'(s_count), 3);
        chk("sat valid", 64'(s_valid), 1);
        idle_in(); icontinuous = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
